// File: rtl/child_result_merger.sv
// Round-robin fan-in of NUM_CH child result channels into one registered, source-tagged output.
// Also keeps a wrapping count of accepted words.
module child_result_merger #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SRC_W-1:0]         out_src,
  output logic [CNT_W-1:0]         txn_count,
  output logic                     idle
);

  logic [SRC_W-1:0]  rr_ptr;
  logic              load_en;
  logic              hi_found, lo_found, grant_any;
  logic [SRC_W-1:0]  hi_idx, lo_idx, grant_idx;
  logic [DATA_W-1:0] sel_data;
  logic              hs;

  assign load_en = !out_valid || out_ready;

  // Two passes: lowest requester at or above rr_ptr wins, otherwise lowest below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i] && (i >= int'(rr_ptr))) begin
        hi_found = 1'b1;
        hi_idx   = SRC_W'(i);
      end
      if (in_valid[i] && (i < int'(rr_ptr))) begin
        lo_found = 1'b1;
        lo_idx   = SRC_W'(i);
      end
    end
    grant_any = hi_found || lo_found;
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == SRC_W'(i)) sel_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load_en && grant_any) in_ready = NUM_CH'(1) << grant_idx;
  end

  assign hs   = |(in_ready & in_valid);
  assign idle = !(|in_valid) && !out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      txn_count <= '0;
      rr_ptr    <= '0;
    end else if (hs) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= grant_idx;
      txn_count <= txn_count + 1'b1;
      rr_ptr    <= (grant_idx == SRC_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
